pipe_reg_skid: RTL and testbench
================================

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of one channel.
REQ-002 The block SHALL have parameter NUM_CH, default 3, giving the number of payload channels (ch0 = instruction, ch1 = pc, ch2 = pc+4).
REQ-003 The block SHALL have parameter BUBBLE_CH0, default 32'h00000013, giving the ch0 value of an inserted bubble (NOP); other channels of a bubble are 0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a payload this cycle.
REQ-008 The block SHALL have port in_data, input, NUM_CH*DATA_WIDTH bits: payload, ch0 in the LSBs.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid payload.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts (low = stall).
REQ-011 The block SHALL have port out_data, output, NUM_CH*DATA_WIDTH bits: head payload, bubble pattern when empty.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous kill of all held and incoming payloads.
REQ-013 The block SHALL have port occupancy, output, 2 bits: number of payloads held (0..2).
REQ-014 The block SHALL have port stall_cnt, output, 32 bits: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a head register (drives out_data) and a skid register; state SHALL be EMPTY, ONE or FULL, encoded as occupancy 0/1/2.
REQ-016 in_ready SHALL equal (state != FULL) and out_valid SHALL equal (state != EMPTY); both derive from registers only, with no combinational path from out_ready or in_valid.
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 From EMPTY, an input transfer SHALL load head with in_data and go to ONE; otherwise the state SHALL stay EMPTY.
REQ-019 From ONE, input and output transfers together SHALL load head with in_data and stay in ONE.
REQ-020 From ONE, an input transfer alone SHALL load skid with in_data and go to FULL, leaving head unchanged.
REQ-021 From ONE, an output transfer alone SHALL load head with the bubble pattern and go to EMPTY.
REQ-022 From ONE, with neither transfer, head SHALL hold.
REQ-023 In FULL, in_ready SHALL be 0; an output transfer SHALL move skid to head and go to ONE; otherwise head and skid SHALL hold.
REQ-024 Payload order SHALL be preserved; latency SHALL be 1 cycle from an input transfer to out_valid; sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-025 flush=1 SHALL have priority over all transfers: the next state is EMPTY, head and skid load the bubble pattern, and any same-cycle input or output transfer is discarded.
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 32'hFFFFFFFF, and be unaffected by flush.
REQ-027 A skid register not currently holding a payload SHALL never reach out_data.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force state EMPTY, occupancy 0, out_valid 0, in_ready 1, head and skid to the bubble pattern, and stall_cnt 0.
REQ-029 Reset asserted mid-operation SHALL drop all held payloads; the first input transfer after release SHALL behave as from EMPTY.

Verification
REQ-030 Reset, then in_valid=1 with ch0=0xAAAA0001, out_ready=1 -> next cycle out_valid=1, out_data ch0=0xAAAA0001, occupancy=1.
REQ-031 Stream 8 payloads back-to-back with out_ready=1 -> 8 consecutive out_valid cycles, in order, in_ready constantly 1.
REQ-032 Hold out_ready=0 and present payloads A, B, C -> A at head, B in skid, occupancy=2, in_ready=0, C not accepted; stall_cnt counts each stalled cycle; raising out_ready -> A, B, C delivered in order.
REQ-033 In FULL state, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data ch0=0x00000013, other channels 0, incoming payload lost.
REQ-034 Hold out_valid=1 with out_ready=0 after preloading stall_cnt near 32'hFFFFFFFF via a long stall -> stall_cnt holds at 32'hFFFFFFFF.
REQ-035 Drive rst=0 asynchronously between clock edges while in FULL -> outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// Two-entry pipeline register with a skid slot so that in_ready/out_valid come straight from state.
// Flush empties both slots; the stall counter tracks back-pressure cycles and saturates.
module pipe_reg_skid #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 3,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_CH0 = DATA_WIDTH'(32'h00000013)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]  out_data,
    input  logic                          flush,
    output logic [1:0]                    occupancy,
    output logic [31:0]                   stall_cnt
);

    localparam int unsigned PW = NUM_CH * DATA_WIDTH;
    localparam logic [PW-1:0] BUBBLE = PW'(BUBBLE_CH0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   head;
    logic [PW-1:0]   skid;
    logic [31:0]     stall_q;
    logic            in_xfer;
    logic            out_xfer;

    // Handshake flags decode the state register only, never the partner's valid/ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_data  = head;
    assign occupancy = 2'(state);
    assign stall_cnt = stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            head    <= BUBBLE;
            skid    <= BUBBLE;
            stall_q <= 32'd0;
        end else begin
            // Back-pressure counter ignores flush so stalls stay visible across kills.
            if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end

            if (flush) begin
                state <= EMPTY;
                head  <= BUBBLE;
                skid  <= BUBBLE;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_xfer) begin
                            head  <= in_data;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        case ({in_xfer, out_xfer})
                            2'b11: head <= in_data;
                            2'b10: begin
                                skid  <= in_data;
                                state <= FULL;
                            end
                            2'b01: begin
                                head  <= BUBBLE;
                                state <= EMPTY;
                            end
                            default: ;
                        endcase
                    end
                    FULL: begin
                        // Skid is cleared on hand-off so stale data can never resurface.
                        if (out_xfer) begin
                            head  <= skid;
                            skid  <= BUBBLE;
                            state <= ONE;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        head  <= BUBBLE;
                        skid  <= BUBBLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_reg_skid;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 3;
    localparam int unsigned PW = DW * NC;
    localparam logic [PW-1:0] BUBBLE = {64'h0, 32'h0000_0013};

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_data;
    logic            flush;
    logic [1:0]      occupancy;
    logic [31:0]     stall_cnt;

    int              checks = 0;
    int              errors = 0;
    logic            check_en = 1'b0;

    // Reference model: ordered list of held payloads plus a saturating stall count.
    logic [PW-1:0]   mq[$];
    logic [31:0]     m_stall;
    logic [PW-1:0]   exp_data;

    always #5 clk = ~clk;

    pipe_reg_skid #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .BUBBLE_CH0 (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int n;
        bit it;
        bit ot;
        if (!rst) begin
            mq.delete();
            m_stall = 32'd0;
            return;
        end
        n  = mq.size();
        it = in_valid && (n < 2);
        ot = out_ready && (n > 0);
        if ((n > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (ot) void'(mq.pop_front());
            if (it) mq.push_back(in_data);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    function automatic logic [PW-1:0] pay(input logic [31:0] tag);
        return {tag + 32'h2000_0000, tag + 32'h1000_0000, tag};
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            exp_data = (mq.size() > 0) ? mq[0] : BUBBLE;
            chk("cyc out_valid", out_valid, mq.size() > 0);
            chk("cyc in_ready", in_ready, mq.size() < 2);
            chk("cyc occupancy", occupancy, mq.size());
            chk("cyc out_data", out_data, exp_data);
            chk("cyc stall_cnt", stall_cnt, m_stall);
        end
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        mq.delete();
        m_stall = 32'd0;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst occupancy", occupancy, 0);
        chk("rst out_data", out_data, BUBBLE);
        chk("rst stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        check_en = 1'b1;

        // Single payload, one-cycle latency
        drive(1'b1, {32'h1111_1111, 32'h2222_2222, 32'hAAAA_0001}, 1'b1, 1'b0);
        cycle();
        chk("first out_valid", out_valid, 1);
        chk("first ch0", out_data[31:0], 32'hAAAA_0001);
        chk("first occupancy", occupancy, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        chk("first drained", occupancy, 0);

        // Back-to-back stream at full rate
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, pay(32'hB000_0000 + 32'(k)), 1'b1, 1'b0);
            chk("stream in_ready", in_ready, 1);
            cycle();
            chk("stream out_valid", out_valid, 1);
            chk("stream out_data", out_data, pay(32'hB000_0000 + 32'(k)));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        chk("stream drained", occupancy, 0);

        // Stall with A, B, C; C refused while full
        drive(1'b1, pay(32'hA), 1'b0, 1'b0);
        cycle();
        drive(1'b1, pay(32'hB), 1'b0, 1'b0);
        cycle();
        drive(1'b1, pay(32'hC), 1'b0, 1'b0);
        cycle();
        chk("stall head A", out_data, pay(32'hA));
        chk("stall occupancy", occupancy, 2);
        chk("stall in_ready", in_ready, 0);
        chk("stall count", stall_cnt, 2);
        drive(1'b1, pay(32'hC), 1'b1, 1'b0);
        cycle();
        chk("release head B", out_data, pay(32'hB));
        chk("release occ B", occupancy, 1);
        cycle();
        chk("release head C", out_data, pay(32'hC));
        chk("release occ C", occupancy, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        chk("release drained", out_valid, 0);

        // Flush while full with a concurrent incoming payload
        drive(1'b1, pay(32'hD), 1'b0, 1'b0);
        cycle();
        drive(1'b1, pay(32'hE), 1'b0, 1'b0);
        cycle();
        chk("pre-flush occupancy", occupancy, 2);
        drive(1'b1, pay(32'hF), 1'b0, 1'b1);
        cycle();
        chk("flush occupancy", occupancy, 0);
        chk("flush out_valid", out_valid, 0);
        chk("flush out_data", out_data, BUBBLE);
        chk("flush stall kept", stall_cnt, 4);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        chk("flush payload lost", occupancy, 0);

        // Stall counter saturation
        drive(1'b1, pay(32'h60), 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        force dut.stall_q = 32'hFFFF_FFF0;
        m_stall = 32'hFFFF_FFF0;
        #1 release dut.stall_q;
        repeat (20) cycle();
        chk("sat stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        chk("sat out_valid", out_valid, 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();

        // Asynchronous reset while full
        drive(1'b1, pay(32'h70), 1'b0, 1'b0);
        cycle();
        drive(1'b1, pay(32'h71), 1'b0, 1'b0);
        cycle();
        chk("pre-rst occupancy", occupancy, 2);
        #2 rst = 1'b0;
        mq.delete();
        m_stall = 32'd0;
        #1;
        chk("async occupancy", occupancy, 0);
        chk("async out_valid", out_valid, 0);
        chk("async in_ready", in_ready, 1);
        chk("async out_data", out_data, BUBBLE);
        chk("async stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, pay(32'h80), 1'b1, 1'b0);
        cycle();
        chk("post-rst head", out_data, pay(32'h80));
        chk("post-rst occupancy", occupancy, 1);

        // Randomized traffic against the model
        repeat (600) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
